dmem_access_unit: RTL and testbench

- Responder for the datapath's data-memory control signals (DMWr, DMRd, DMCtrl).
- Converts a single core-side request into one word-aligned transaction on a latency-tolerant memory port.
- Generates byte enables, extends load data by access width, and detects misaligned, illegal and timed-out accesses.
- Sits between the execute/memory stage and the data RAM/bus.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_load_align.sv | 18 +
 rtl/dmem_access_unit.sv | 129 ++++++++++++
 tb/tb_dmem_access_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: DMCtrl encodings, fault codes, FSM states and lane helpers shared by the data-memory access unit
package dmem_pkg;
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_t;
  function automatic logic [3:0] be_of(input logic [2:0] ctrl, input logic [1:0] off);
    return ctrl[1] ? 4'b1111 : ctrl[0] ? 4'b0011 << off : 4'b0001 << off;
  endfunction
  function automatic logic [31:0] wdata_of(input logic [2:0] ctrl, input logic [31:0] wd);
    return ctrl[1] ? wd : ctrl[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: extracts the addressed byte/halfword from a read word and sign/zero-extends by DMCtrl (rdata, off, ctrl -> data)
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ctrl,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[8*off +: 8];
    h = rdata[16*off[1] +: 16];
    data = ctrl[1] ? rdata :
           ctrl[0] ? {{16{h[15] & ~ctrl[2]}}, h} : {{24{b[7] & ~ctrl[2]}}, b};
  end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: turns one DMWr/DMRd/DMCtrl core request into a word-aligned memory transaction with byte enables, load extension and misalign/illegal/timeout faults
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req,
  input  logic              DMWr,
  input  logic              DMRd,
  input  logic [2:0]        DMCtrl,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WrData,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       RdData,
  output logic              Fault,
  output logic [1:0]        FaultCode,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemBe,
  output logic [31:0]       MemWData,
  input  logic              MemGnt,
  input  logic              MemRValid,
  input  logic [31:0]       MemRData
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [2:0] ctrl_q;
  logic [1:0] off_q;
  logic [CW-1:0] cnt;
  logic [31:0] ld_data;
  logic bad_ctrl, misalign;
  logic [1:0] flt;
  always_comb begin
    bad_ctrl = (DMWr & DMRd) | (DMCtrl == 3'b011) | (DMCtrl[2:1] == 2'b11) | (DMWr & DMCtrl[2]);
    misalign = (DMCtrl[1:0] == 2'b01 & Addr[0]) | (DMCtrl == DM_W & Addr[1:0] != 2'b00);
    flt = bad_ctrl ? FLT_ILLEGAL : misalign ? FLT_MISALIGN : FLT_NONE;
  end
  dmem_load_align u_align (
    .rdata(MemRData),
    .off  (off_q),
    .ctrl (ctrl_q),
    .data (ld_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      RdData <= '0;
      Fault <= 1'b0;
      FaultCode <= FLT_NONE;
      MemReq <= 1'b0;
      MemWe <= 1'b0;
      MemAddr <= '0;
      MemBe <= '0;
      MemWData <= '0;
      ctrl_q <= '0;
      off_q <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (Req && (DMWr || DMRd)) begin
          Busy <= 1'b1;
          ctrl_q <= DMCtrl;
          off_q <= Addr[1:0];
          cnt <= '0;
          if (flt != FLT_NONE) begin
            state <= RESP;
            Done <= 1'b1;
            Fault <= 1'b1;
            FaultCode <= flt;
            RdData <= '0;
          end else begin
            state <= MEM_REQ;
            MemReq <= 1'b1;
            MemWe <= DMWr;
            MemAddr <= {Addr[ADDR_W-1:2], 2'b00};
            MemBe <= be_of(DMCtrl, Addr[1:0]);
            MemWData <= wdata_of(DMCtrl, WrData);
          end
        end
        MEM_REQ: if (MemGnt) begin
          MemReq <= 1'b0;
          cnt <= '0;
          state <= MemWe ? RESP : MEM_WAIT;
          Done <= MemWe;
          Fault <= 1'b0;
          FaultCode <= FLT_NONE;
          RdData <= '0;
        end else if (cnt == LAST) begin
          MemReq <= 1'b0;
          state <= RESP;
          Done <= 1'b1;
          Fault <= 1'b1;
          FaultCode <= FLT_TIMEOUT;
          RdData <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        MEM_WAIT: if (MemRValid) begin
          state <= RESP;
          Done <= 1'b1;
          Fault <= 1'b0;
          FaultCode <= FLT_NONE;
          RdData <= ld_data;
        end else if (cnt == LAST) begin
          state <= RESP;
          Done <= 1'b1;
          Fault <= 1'b1;
          FaultCode <= FLT_TIMEOUT;
          RdData <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          Done <= 1'b0;
          Busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed vectors with hand-computed expectations for dmem_access_unit (TIMEOUT_CYCLES=4)
module tb_dmem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Req = 1'b0, DMWr = 1'b0, DMRd = 1'b0;
  logic [2:0] DMCtrl = '0;
  logic [31:0] Addr = '0, WrData = '0;
  logic Busy, Done, Fault, MemReq, MemWe;
  logic [31:0] RdData, MemAddr, MemWData;
  logic [1:0] FaultCode;
  logic [3:0] MemBe;
  logic MemGnt = 1'b0, MemRValid = 1'b0;
  logic [31:0] MemRData = '0;
  int n = 0;
  int errs = 0;
  dmem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .DMWr(DMWr), .DMRd(DMRd), .DMCtrl(DMCtrl),
    .Addr(Addr), .WrData(WrData), .Busy(Busy), .Done(Done), .RdData(RdData),
    .Fault(Fault), .FaultCode(FaultCode), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemBe(MemBe), .MemWData(MemWData), .MemGnt(MemGnt),
    .MemRValid(MemRValid), .MemRData(MemRData)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic wr, input logic rd, input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] wd);
    Req = 1'b1; DMWr = wr; DMRd = rd; DMCtrl = ctrl; Addr = a; WrData = wd;
    tick;
    Req = 1'b0; DMWr = 1'b0; DMRd = 1'b0;
  endtask
  task automatic do_store(input string tag, input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd);
    issue(1'b1, 1'b0, ctrl, a, wd);
    chk({tag, " memreq"}, MemReq, 1);
    chk({tag, " memwe"}, MemWe, 1);
    chk({tag, " memaddr"}, MemAddr, ea);
    chk({tag, " membe"}, MemBe, ebe);
    chk({tag, " memwdata"}, MemWData, ewd);
    chk({tag, " done early"}, Done, 0);
    MemGnt = 1'b1;
    tick;
    MemGnt = 1'b0;
    chk({tag, " done"}, Done, 1);
    chk({tag, " fault"}, Fault, 0);
    chk({tag, " memreq drop"}, MemReq, 0);
    tick;
    chk({tag, " done pulse"}, Done, 0);
    chk({tag, " idle"}, Busy, 0);
  endtask
  task automatic do_load(input string tag, input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] rd,
                         input int lat, input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] exp);
    issue(1'b0, 1'b1, ctrl, a, 32'h0);
    chk({tag, " memreq"}, MemReq, 1);
    chk({tag, " memwe"}, MemWe, 0);
    chk({tag, " memaddr"}, MemAddr, ea);
    chk({tag, " membe"}, MemBe, ebe);
    MemGnt = 1'b1;
    tick;
    MemGnt = 1'b0;
    chk({tag, " memreq wait"}, MemReq, 0);
    repeat (lat) begin
      chk({tag, " done early"}, Done, 0);
      tick;
    end
    MemRValid = 1'b1; MemRData = rd;
    tick;
    MemRValid = 1'b0; MemRData = 32'hDEADBEEF;
    chk({tag, " done"}, Done, 1);
    chk({tag, " rddata"}, RdData, exp);
    chk({tag, " fault"}, Fault, 0);
    tick;
    chk({tag, " done pulse"}, Done, 0);
  endtask
  task automatic do_fault(input string tag, input logic wr, input logic rd, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [1:0] code);
    issue(wr, rd, ctrl, a, 32'hFFFF_FFFF);
    chk({tag, " done"}, Done, 1);
    chk({tag, " code"}, FaultCode, code);
    chk({tag, " fault"}, Fault, 1);
    chk({tag, " rddata"}, RdData, 0);
    chk({tag, " no memreq"}, MemReq, 0);
    tick;
    chk({tag, " done pulse"}, Done, 0);
    chk({tag, " no memreq after"}, MemReq, 0);
  endtask
  initial begin
    #1;
    chk("rst busy", Busy, 0);
    chk("rst done", Done, 0);
    chk("rst memreq", MemReq, 0);
    chk("rst rddata", RdData, 0);
    chk("rst faultcode", FaultCode, 0);
    #12 rst_n = 1'b1;
    tick;
    Req = 1'b1;
    tick;
    Req = 1'b0;
    chk("req no dir ignored", Busy, 0);
    do_store("sb", 3'b000, 32'h1003, 32'h0000_00A5, 32'h1000, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", 3'b001, 32'h1002, 32'h1234_BEEF, 32'h1000, 4'b1100, 32'hBEEF_BEEF);
    do_store("sw", 3'b010, 32'h4008, 32'hCAFE_F00D, 32'h4008, 4'b1111, 32'hCAFE_F00D);
    do_load("lb", 3'b000, 32'h2002, 32'h0080_FF00, 2, 32'h2000, 4'b0100, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h2002, 32'h0080_FF00, 2, 32'h2000, 4'b0100, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h2002, 32'h8001_7F00, 0, 32'h2000, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h2002, 32'h8001_7F00, 1, 32'h2000, 4'b1100, 32'h0000_8001);
    do_load("lh lo", 3'b001, 32'h2000, 32'h8001_7F00, 0, 32'h2000, 4'b0011, 32'h0000_7F00);
    do_fault("lh mis", 1'b0, 1'b1, 3'b001, 32'h2001, 2'b01);
    do_fault("sw mis", 1'b1, 1'b0, 3'b010, 32'h2006, 2'b01);
    do_fault("ctrl011", 1'b0, 1'b1, 3'b011, 32'h2000, 2'b10);
    do_fault("wr+rd", 1'b1, 1'b1, 3'b010, 32'h2000, 2'b10);
    do_fault("sbu", 1'b1, 1'b0, 3'b100, 32'h2000, 2'b10);
    do_fault("ill over mis", 1'b0, 1'b1, 3'b111, 32'h2001, 2'b10);
    issue(1'b0, 1'b1, 3'b010, 32'h3000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to memreq", MemReq, 1);
      chk("to done early", Done, 0);
      tick;
    end
    chk("to done", Done, 1);
    chk("to code", FaultCode, 2'b11);
    chk("to memreq drop", MemReq, 0);
    MemGnt = 1'b1;
    tick;
    MemGnt = 1'b0;
    chk("late gnt busy", Busy, 0);
    chk("late gnt memreq", MemReq, 0);
    chk("late gnt done", Done, 0);
    tick;
    chk("late gnt still idle", Busy, 0);
    issue(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    MemGnt = 1'b1;
    tick;
    MemGnt = 1'b0;
    chk("mw busy", Busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst memreq", MemReq, 0);
    chk("arst busy", Busy, 0);
    chk("arst done", Done, 0);
    MemRValid = 1'b1; MemRData = 32'h5555_5555;
    tick;
    MemRValid = 1'b0;
    chk("arst no done", Done, 0);
    rst_n = 1'b1;
    tick;
    do_load("lw", 3'b010, 32'h0, 32'h1234_5678, 0, 32'h0, 4'b1111, 32'h1234_5678);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
